// File: rtl/sd_pkg.sv
// Shared definitions for the "101" detector scheduler.
//   sd_state_e : scheduler FSM encoding (IDLE=0, CLR=1, SHIFT=2, DONE=3)
//   SD_PATTERN : the serial pattern the shared detector recognises
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } sd_state_e;

    localparam logic [2:0] SD_PATTERN = 3'b101;

endpackage

// File: rtl/sd_rr_arbiter.sv
// Combinational round-robin pick.
//   req    : request levels, one per requester
//   rr_ptr : highest-priority requester this round
//   gnt    : one-hot grant of the first set req bit at or after rr_ptr (wraps)
//   id     : encoded index of gnt (0 when req is empty)
module sd_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id
);

    always_comb begin : pick
        logic found;
        int   k;
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // Walk the ring starting at rr_ptr; modulo done by one subtract
            // since rr_ptr < N_REQ and i < N_REQ.
            k = int'(rr_ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                id     = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/sd_101_scheduler.sv
// Shares one external "101" Mealy detector between N_REQ requesters.
// A granted word is shifted MSB-first into the detector after a one-cycle
// detector clear; hits are counted and returned with the requester id.
//   clk, reset  : clock, asynchronous active-low reset
//   req/word_in : request levels and packed words (requester i at [i*WORD_W +: WORD_W])
//   grant, busy : one-hot grant held for the whole service; FSM not idle
//   sd_reset    : detector clear (active-high), sd_din: serial bit, sd_dout: detector hit
//   done        : one-cycle completion pulse with done_id and match_cnt
module sd_101_scheduler
    import sd_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1),
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] word_in,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    sd_reset,
    output logic                    sd_din,
    input  logic                    sd_dout,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [CNT_W-1:0]        match_cnt
);

    localparam int BI_W = $clog2(WORD_W);

    sd_state_e         state_q, state_d;
    logic [N_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]   arb_id;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [WORD_W-1:0] sel_word;
    logic [WORD_W-1:0] shreg;
    logic [BI_W-1:0]   bit_idx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              last_bit;

    sd_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt),
        .id     (arb_id)
    );

    // One-hot mux of the winning requester's word.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_REQ; i++)
            if (arb_gnt[i]) sel_word = sel_word | word_in[i*WORD_W +: WORD_W];
    end

    assign last_bit = (bit_idx == '0);
    // Detector output is Mealy: the hit belongs to the bit shown this cycle.
    assign cnt_next = cnt + CNT_W'(sd_dout);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = CLR;
            CLR:     state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            sd_reset  <= 1'b1;
            sd_din    <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            match_cnt <= '0;
            rr_ptr    <= '0;
            cur_id    <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
        end else begin
            state_q  <= state_d;
            busy     <= (state_d != IDLE);
            sd_reset <= (state_d == CLR);
            done     <= (state_d == DONE);
            sd_din   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant  <= arb_gnt;
                        cur_id <= arb_id;
                        shreg  <= sel_word;
                    end
                end
                CLR: begin
                    // Present the MSB for the first SHIFT cycle; shreg always
                    // holds the next bit to send at its top.
                    bit_idx <= BI_W'(WORD_W - 1);
                    cnt     <= '0;
                    sd_din  <= shreg[WORD_W-1];
                    shreg   <= {shreg[WORD_W-2:0], 1'b0};
                end
                SHIFT: begin
                    cnt <= cnt_next;
                    if (last_bit) begin
                        match_cnt <= cnt_next;
                        done_id   <= cur_id;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                        sd_din  <= shreg[WORD_W-1];
                        shreg   <= {shreg[WORD_W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    grant  <= '0;
                    rr_ptr <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_101_scheduler.sv
module tb_sd_101_scheduler;

    localparam int N_REQ  = 4;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;
    localparam int ID_W   = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*WORD_W-1:0] word_in = '0;
    logic [N_REQ-1:0]        grant;
    logic                    busy, sd_reset, sd_din, sd_dout, done;
    logic [ID_W-1:0]         done_id;
    logic [CNT_W-1:0]        match_cnt;

    typedef struct { int id; int cnt; } exp_t;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sd_101_scheduler #(.N_REQ(N_REQ), .WORD_W(WORD_W)) dut (
        .clk(clk), .reset(reset), .req(req), .word_in(word_in),
        .grant(grant), .busy(busy), .sd_reset(sd_reset), .sd_din(sd_din),
        .sd_dout(sd_dout), .done(done), .done_id(done_id), .match_cnt(match_cnt)
    );

    // Stand-in for the shared overlapping "101" Mealy detector.
    logic [1:0] det_st;
    always @(posedge clk or posedge sd_reset) begin
        if (sd_reset) det_st <= 2'd0;
        else case (det_st)
            2'd0:    det_st <= sd_din ? 2'd1 : 2'd0;
            2'd1:    det_st <= sd_din ? 2'd1 : 2'd2;
            default: det_st <= sd_din ? 2'd1 : 2'd0;
        endcase
    end
    assign sd_dout = (det_st == 2'd2) && sd_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got id %0d cnt %0d expected none", done_id, match_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_id", done_id, e.id);
                chk("match_cnt", match_cnt, e.cnt);
            end
        end
    end

    task automatic serve(input logic [3:0] mask, input int id, input logic [7:0] w, input int exp_cnt);
        int n;
        @(negedge clk);
        word_in[id*WORD_W +: WORD_W] = w;
        req = mask;
        exp_q.push_back('{id: id, cnt: exp_cnt});
        n = 0;
        while (grant == '0 && n < 20) begin @(negedge clk); n++; end
        chk("grant_timeout", (grant == '0), 0);
        chk("grant_onehot", grant, 32'(1) << id);
        chk("clr_sd_reset", sd_reset, 1);
        chk("clr_busy", busy, 1);
        req = '0;
        for (int b = WORD_W - 1; b >= 0; b--) begin
            @(negedge clk);
            chk("sd_din", sd_din, w[b]);
            if (b == WORD_W - 1) chk("shift_sd_reset", sd_reset, 0);
        end
        @(negedge clk);
        chk("done_latency9", done, 1);
        @(negedge clk);
        chk("idle_grant", grant, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    task automatic wait_done(output int stamp);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 30);
        chk("done_timeout", done, 1);
        stamp = cyc;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int prev, stamp;
        logic [7:0] rr_cnt [4];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_sd_din", sd_din, 0);
        chk("rst_sd_reset", sd_reset, 1);
        reset = 1'b1;

        // 1: single word
        serve(4'b0001, 0, 8'b1010_0101, 2);
        // 3: cross-word isolation (word boundary "10" + "1" must not match)
        serve(4'b0001, 0, 8'b0000_0010, 0);
        serve(4'b0010, 1, 8'b1000_0000, 0);
        // 2: overlap and no-match; leaves rr_ptr at 0
        serve(4'b0100, 2, 8'b1010_1010, 3);
        serve(4'b1000, 3, 8'hFF, 0);
        serve(4'b1000, 3, 8'h00, 0);

        // 4: round robin with all requesters held
        rr_cnt[0] = 8'd2; rr_cnt[1] = 8'd3; rr_cnt[2] = 8'd0; rr_cnt[3] = 8'd1;
        @(negedge clk);
        word_in = {8'h05, 8'hFF, 8'hAA, 8'hA5};
        req = 4'b1111;
        begin
            int ord[9] = '{0, 1, 2, 3, 0, 1, 2, 0, 2};
            foreach (ord[i]) exp_q.push_back('{id: ord[i], cnt: int'(rr_cnt[ord[i]])});
        end
        prev = 0;
        for (int k = 0; k < 9; k++) begin
            wait_done(stamp);
            if (k > 0) chk("rr_spacing", stamp - prev, 11);
            prev = stamp;
            if (k == 6) req = 4'b0101;
            if (k == 7) begin
                @(negedge clk);
                @(negedge clk);
                chk("grant_after_switch", grant, 4'b0100);
                req = '0;
            end
        end
        repeat (3) @(negedge clk);

        // 5: reset in the 4th SHIFT cycle; rr_ptr is now 3
        word_in[3*WORD_W +: WORD_W] = 8'b1010_1010;
        req = 4'b1000;
        begin
            int n;
            n = 0;
            while (grant == '0 && n < 20) begin @(negedge clk); n++; end
        end
        chk("abort_grant", grant, 4'b1000);
        req = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_grant_low", grant, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sd_reset", sd_reset, 1);
        chk("abort_done", done, 0);
        repeat (2) @(negedge clk);
        chk("abort_no_done", done, 0);
        reset = 1'b1;
        // rr_ptr back to 0: with 3 and 1 requesting, 1 must win
        serve(4'b1010, 1, 8'b1011_0101, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_101_scheduler.md
# sd_101_scheduler

Shares one `sd_101_mealy` "101" sequence detector between `N_REQ` requesters.
- Each requester offers a `WORD_W`-bit word.
- The scheduler grants one requester at a time in round-robin order and clears the detector.
- It shifts the granted word into the detector MSB-first, one bit per clock, and counts detector hits.
- It returns the overlapping-match count tagged with the requester id.
- It sits between the requester logic and the single detector instance; the detector's `led` output is not used.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, ≥2.
- `WORD_W`, default 8: bits per word, ≥3.
- `CNT_W`, default `$clog2(WORD_W+1)`: width of the match count.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester id.

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `reset`, in, 1: asynchronous, active-low. `reset`=0 clears all state immediately.
- `req`, in, `N_REQ`: per-requester request level. The requester holds it until its `grant` bit rises.
- `word_in`, in, `N_REQ*WORD_W`: requester i word occupies bits [i*WORD_W +: WORD_W].
- `grant`, out, `N_REQ`: one-hot, registered. High for the whole service of a requester.
- `busy`, out, 1: registered, high whenever the FSM is not in IDLE.
- `sd_reset`, out, 1: detector reset, active-high, registered.
- `sd_din`, out, 1: serial bit to the detector `din`, registered.
- `sd_dout`, in, 1: detector Mealy output.
- `done`, out, 1: one-cycle pulse marking a completed word.
- `done_id`, out, `ID_W`: index of the serviced requester. Valid while `done`=1.
- `match_cnt`, out, `CNT_W`: number of "101" matches in the word. Valid while `done`=1.

## Operation

FSM states: IDLE, CLR, SHIFT, DONE.

- **IDLE**
  - If `req`≠0, choose the first set bit at or after `rr_ptr`, wrapping around.
  - Register `grant` one-hot and `cur_id`.
  - Latch that requester's word into `shreg`. This is the only sampling point for `word_in`.
  - Go to CLR. If `req`=0, stay in IDLE.
- **CLR**
  - `sd_reset`=1 for exactly one cycle. This clears any detector state left by the previous word, so matches never span words.
  - Load `bit_idx`=WORD_W-1 and `cnt`=0.
  - Go to SHIFT.
- **SHIFT**
  - Drive `sd_din`=`shreg[bit_idx]`.
  - At each rising edge, if `sd_dout`=1, increment `cnt`. The Mealy output is valid within the same cycle the bit is presented.
  - Decrement `bit_idx`. After sampling bit 0, go to DONE.
- **DONE**
  - `done`=1, `match_cnt`=`cnt`, `done_id`=`cur_id`.
  - Set `rr_ptr`=`cur_id`+1, wrapping modulo `N_REQ`.
  - `grant` returns to 0 at the end of this cycle. Go to IDLE.

Rules:
- Matching is overlapping: bits 1,0,1,0,1 give 2 matches.
- `cnt` is sized to hold `WORD_W` and never saturates.
- `req` changes while `grant` is high are ignored. A requester wanting a second word keeps `req` high; it is served again on its next round-robin turn.
- Reset values:
  - `grant`=0, `busy`=0, `done`=0, `done_id`=0, `match_cnt`=0, `sd_din`=0.
  - `sd_reset`=1 while `reset`=0, so the detector is held cleared.
  - `rr_ptr`=0, state = IDLE.
- Reset asserted mid-SHIFT: service is aborted immediately, no `done` is produced, and `grant` drops asynchronously.

## Timing

- Edge E0: IDLE samples `req`≠0.
  - Cycle after E0: `grant` and `busy` are high, and the FSM is in CLR.
  - Next `WORD_W` cycles: SHIFT.
  - Following cycle: DONE.
- Grant to `done`: `WORD_W`+1 cycles. With `WORD_W`=8, `done` appears 9 cycles after `grant` rises.
- One IDLE cycle always separates services.
- Back-to-back throughput is one word per `WORD_W`+3 cycles (11 cycles for `WORD_W`=8).
- `done` and `grant` fall together at the DONE→IDLE edge.

## Structure

- Shared package `sd_pkg` holds:
  - the FSM state localparams (IDLE=0, CLR=1, SHIFT=2, DONE=3);
  - the detection pattern constant 3'b101 for documentation and benches.
- Sub-module `sd_rr_arbiter`: combinational round-robin pick. Inputs are `req` and `rr_ptr`; outputs are one-hot `gnt` and encoded `id`.
- The FSM, shift register and counter live in `sd_101_scheduler`.
- The detector is instantiated by the parent, not inside this block.

## Test plan

1. **Single word.** `reset` low 2 cycles then high; `req`=4'b0001 with word 8'b1010_0101. Expect `grant`=0001, `sd_din` sequence 1,0,1,0,0,1,0,1, then `done`=1, `done_id`=0, `match_cnt`=2, exactly 9 cycles after `grant` rises.
2. **Overlap and no-match.** Word 8'b1010_1010 gives `match_cnt`=3. Word 8'hFF gives 0. Word 8'h00 gives 0.
3. **Cross-word isolation.** Requester 0 sends 8'b0000_0010, then requester 1 sends 8'b1000_0000. Expect both `match_cnt`=0, and `sd_reset` pulses one cycle before each word.
4. **Round-robin.** `req`=4'b1111 held throughout. Expect grant order 0,1,2,3,0, with `done` pulses 11 cycles apart. Then `req`=4'b0101 after id 2: next grant is 0, then 2.
5. **Reset mid-shift.** Assert `reset`=0 during the 4th SHIFT cycle. Expect `grant`=0, `busy`=0, `sd_reset`=1 immediately, and no `done`. After release with `req`=4'b0010, service starts from requester 1 with `rr_ptr`=0 semantics.
